upsampler_wrap: RTL and testbench

- 2x nearest-neighbour image upsampler for the feature-detection pixel pipeline.
- Input: raster-order 8-bit greyscale pixel stream at IN_WIDTH x IN_HEIGHT.
- Output: raster-order stream at 2*IN_WIDTH x 2*IN_HEIGHT, with the output row/column coordinate of every emitted pixel.
- Each input pixel is emitted twice horizontally; each input row is emitted twice vertically.
- An internal input FIFO absorbs bursts. There is no backpressure to the producer.

---
 rtl/upsampler_wrap.sv | 180 ++++++++++++++++++
 tb/tb_upsampler_wrap.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/upsampler_wrap.sv
// rtl/upsampler_wrap.sv - 2x nearest-neighbour greyscale upsampler with input FIFO and line buffer
module upsampler_wrap #(
    parameter int IN_WIDTH   = 400,
    parameter int IN_HEIGHT  = 300,
    parameter int FIFO_DEPTH = 1024,
    parameter int DW         = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid,
    input  logic [DW-1:0] din,
    output logic [9:0]    rownum,
    output logic [9:0]    colnum,
    output logic [DW-1:0] dataout,
    output logic          validout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IN_WIDTH);
    localparam logic [9:0] OUT_W_LAST = 10'(2 * IN_WIDTH - 1);
    localparam logic [9:0] OUT_H_LAST = 10'(2 * IN_HEIGHT - 1);

    typedef enum logic {PASS_A, PASS_B} state_t;

    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [DW-1:0] line_mem [IN_WIDTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_empty, fifo_full, push, pop;
    logic [DW-1:0] fifo_rdata, lb_rdata;

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic          phase, phase_nxt;
    logic          lb_re, iss_valid, iss_first, iss_fifo;

    logic          s1_valid, s1_first, s1_fifo;
    logic [CW-1:0] s1_col;
    logic          lb_we;
    logic [9:0]    nxt_col, nxt_row;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign push       = valid && (!fifo_full || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= din;
        if (pop)  fifo_rdata <= fifo_mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (lb_we) line_mem[s1_col] <= fifo_rdata;
        if (lb_re) lb_rdata <= line_mem[col];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= PASS_A;
            col   <= '0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            phase <= phase_nxt;
        end
    end

    // phase 0 issues the first copy of a pair (fetching the pixel), phase 1 the repeat.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        phase_nxt = phase;
        pop       = 1'b0;
        lb_re     = 1'b0;
        iss_valid = 1'b0;
        iss_first = 1'b0;
        iss_fifo  = 1'b0;
        case (state)
            PASS_A: begin
                if (!phase) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        iss_valid = 1'b1;
                        iss_first = 1'b1;
                        iss_fifo  = 1'b1;
                        phase_nxt = 1'b1;
                    end
                end else begin
                    iss_valid = 1'b1;
                    phase_nxt = 1'b0;
                    if (col == CW'(IN_WIDTH - 1)) begin
                        col_nxt   = '0;
                        state_nxt = PASS_B;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            PASS_B: begin
                iss_valid = 1'b1;
                if (!phase) begin
                    lb_re     = 1'b1;
                    iss_first = 1'b1;
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (col == CW'(IN_WIDTH - 1)) begin
                        col_nxt   = '0;
                        state_nxt = PASS_A;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            default: state_nxt = PASS_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_fifo  <= 1'b0;
            s1_col   <= '0;
        end else begin
            s1_valid <= iss_valid;
            s1_first <= iss_first;
            s1_fifo  <= iss_fifo;
            s1_col   <= col;
        end
    end

    assign lb_we = s1_valid && s1_first && s1_fifo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            validout <= 1'b0;
            dataout  <= '0;
            rownum   <= '0;
            colnum   <= '0;
            nxt_col  <= '0;
            nxt_row  <= '0;
        end else begin
            validout <= s1_valid;
            if (s1_valid) begin
                if (s1_first) dataout <= s1_fifo ? fifo_rdata : lb_rdata;
                colnum <= nxt_col;
                rownum <= nxt_row;
                if (nxt_col == OUT_W_LAST) begin
                    nxt_col <= '0;
                    nxt_row <= (nxt_row == OUT_H_LAST) ? 10'd0 : nxt_row + 10'd1;
                end else begin
                    nxt_col <= nxt_col + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_upsampler_wrap.sv
// tb/tb_upsampler_wrap.sv - randomized self-checking bench for upsampler_wrap
module tb_upsampler_wrap;

    localparam int W = 20;
    localparam int H = 4;
    localparam int D = 48;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] din   = 8'd0;
    logic [9:0] rownum, colnum;
    logic [7:0] dataout;
    logic       validout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] inp[$];
    logic [7:0] got_d[$];
    logic [9:0] got_r[$];
    logic [9:0] got_c[$];
    int         got_t[$];

    upsampler_wrap #(.IN_WIDTH(W), .IN_HEIGHT(H), .FIFO_DEPTH(D), .DW(8)) dut (
        .clock(clock), .reset(reset), .valid(valid), .din(din),
        .rownum(rownum), .colnum(colnum), .dataout(dataout), .validout(validout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset && validout === 1'b1) begin
            got_d.push_back(dataout);
            got_r.push_back(rownum);
            got_c.push_back(colnum);
            got_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        inp.delete(); got_d.delete(); got_r.delete(); got_c.delete(); got_t.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; valid = 1'b0; din = 8'd0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        clear_q();
    endtask

    task automatic send(input logic [7:0] p);
        @(negedge clock);
        valid = 1'b1; din = p;
        inp.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            valid = 1'b0;
        end
    endtask

    // Reference: the k-th output is input pixel (row k/(2W)/2, col (k%(2W))/2);
    // every accepted input row yields 4W outputs, a trailing partial row 2 per pixel.
    task automatic check_stream(input string name);
        int n, exp_n, lim, errs, orow, ocol, idx, er;
        logic mis;
        n     = inp.size();
        exp_n = (n / W) * 4 * W + 2 * (n % W);
        check({name, "_count"}, got_d.size(), exp_n);
        lim  = (got_d.size() < exp_n) ? got_d.size() : exp_n;
        errs = 0;
        for (int k = 0; k < lim && errs < 8; k++) begin
            orow = k / (2 * W);
            ocol = k % (2 * W);
            idx  = (orow / 2) * W + ocol / 2;
            er   = orow % (2 * H);
            mis  = {got_r[k], got_c[k], got_d[k]} !== {10'(er), 10'(ocol), inp[idx]};
            if (mis) errs++;
            check({name, "_pix"}, {got_r[k], got_c[k], got_d[k]}, {10'(er), 10'(ocol), inp[idx]});
            if ((ocol % 2 == 1) || (orow % 2 == 1)) begin
                if (got_t[k] != got_t[k-1] + 1) errs++;
                check({name, "_contig"}, got_t[k], got_t[k-1] + 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [7:0] p;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_validout", validout, 0);
        check("rst_rownum", rownum, 0);
        check("rst_colnum", colnum, 0);
        check("rst_dataout", dataout, 0);
        reset = 1'b1;
        idle(4);
        check("rst_idle_validout", validout, 0);

        // single pixel: latency and pair duplication
        do_reset();
        idle(2);
        @(negedge clock);
        valid = 1'b1; din = 8'h2A; c0 = cyc;
        idle(12);
        check("single_count", got_d.size(), 2);
        if (got_d.size() == 2) begin
            check("single_d0", got_d[0], 8'h2A);
            check("single_d1", got_d[1], 8'h2A);
            check("single_c0", got_c[0], 0);
            check("single_c1", got_c[1], 1);
            check("single_r0", got_r[0], 0);
            check("single_r1", got_r[1], 0);
            check("single_t0", got_t[0], c0 + 3);
            check("single_t1", got_t[1], c0 + 4);
        end

        // back-to-back burst of two input rows
        do_reset();
        for (int i = 0; i < 2 * W; i++) send(8'($urandom));
        idle(400);
        check_stream("burst");

        // stall in the middle of a PASS_A row
        do_reset();
        for (int i = 0; i < W / 2; i++) send(8'($urandom));
        idle(200);
        for (int i = 0; i < W / 2; i++) send(8'($urandom));
        idle(400);
        check_stream("stall");
        if (got_t.size() > W) check("stall_gap", (got_t[W] - got_t[W-1]) > 1, 1);
        else check("stall_gap_size", got_t.size(), 4 * W);

        // overflow: during a 4W-cycle burst one row (W pixels) is popped, then the
        // consumer replays for 2W cycles, so D+W pixels are accepted and the rest dropped
        do_reset();
        for (int i = 0; i < 4 * W; i++) begin
            p = 8'($urandom);
            @(negedge clock);
            valid = 1'b1; din = p;
            if (i < D + W) inp.push_back(p);
        end
        idle(400);
        for (int i = 0; i < W - ((D + W) % W); i++) begin
            send(8'($urandom));
            idle(3);
        end
        idle(400);
        check_stream("ovf");

        // full frame at one pixel per four clocks, plus one row of the next frame
        do_reset();
        for (int i = 0; i < W * H + W; i++) begin
            send(8'($urandom));
            idle(3);
        end
        idle(400);
        check_stream("frame");
        if (got_r.size() > 4 * W * H) begin
            check("frame_last_row", got_r[4*W*H-1], 2 * H - 1);
            check("frame_last_col", got_c[4*W*H-1], 2 * W - 1);
            check("frame_wrap_row", got_r[4*W*H], 0);
            check("frame_wrap_col", got_c[4*W*H], 0);
        end else begin
            check("frame_size", got_r.size(), 4 * W * H + 4 * W);
        end

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < W + 5; i++) send(8'($urandom));
        idle(10);
        check("midrst_active", got_d.size() > 0, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_validout", validout, 0);
        check("midrst_rownum", rownum, 0);
        check("midrst_colnum", colnum, 0);
        @(negedge clock);
        valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom));
            idle(3);
        end
        idle(300);
        check_stream("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
